bsg_cache_req_arbiter: RTL and testbench
========================================

BSG_CACHE_REQ_ARBITER -- requirements
Module: bsg_cache_req_arbiter

Interface
REQ-001 The block SHALL have parameter num_req_p, default 2, giving the number of requesters sharing one bsg_cache (range 2..8).
REQ-002 The block SHALL have parameter pkt_width_p, default bsg_cache_pkt_width(32,32), giving the cache packet width.
REQ-003 The block SHALL have parameter data_width_p, default 32, giving the cache response width.
REQ-004 The block SHALL have parameter outstanding_p, default 4, giving the maximum number of accepted-but-unanswered requests (power of 2, >=2).
REQ-005 The block SHALL use one clock and an asynchronous active-high reset: clk_i input 1, rising-edge clock; reset_i input 1, asynchronous, active-high.
REQ-006 The block SHALL have port req_pkt_i, input, num_req_p*pkt_width_p bits: per-requester packet, slot i at bits [i*pkt_width_p +: pkt_width_p].
REQ-007 The block SHALL have ports req_v_i (input, num_req_p) and req_yumi_o (output, num_req_p): per-requester valid-yumi request handshake.
REQ-008 The block SHALL have ports cache_pkt_o (output, pkt_width_p), cache_v_o (output, 1) and cache_yumi_i (input, 1): the request to the cache.
REQ-009 The block SHALL have ports cache_data_i (input, data_width_p), cache_v_i (input, 1) and cache_yumi_o (output, 1): the response from the cache.
REQ-010 The block SHALL have ports resp_data_o (output, data_width_p), resp_v_o (output, num_req_p) and resp_yumi_i (input, num_req_p): per-requester responses.
REQ-011 The block SHALL have port outstanding_o, output, $clog2(outstanding_p+1) bits: count of requests in flight.

Function
REQ-012 The block SHALL grant round-robin: the lowest index i at or after rr_ptr, modulo num_req_p, with req_v_i[i]=1.
REQ-013 The block SHALL drive cache_v_o = (any req_v_i) & ~full, combinationally.
REQ-014 The block SHALL drive cache_pkt_o with the packet of the granted requester.
REQ-015 The block SHALL assert req_yumi_o[g] only as cache_yumi_i & cache_v_o for the granted requester g; all other req_yumi_o bits SHALL be 0.
REQ-016 The grant SHALL be a pure function of req_v_i and rr_ptr, and rr_ptr SHALL change only on an accepted request, so the grant stays stable while cache_v_o waits for cache_yumi_i.
REQ-017 On an accepted request (cache_v_o & cache_yumi_i), rr_ptr SHALL become (g+1) mod num_req_p and g SHALL be pushed into an in-order ID FIFO of depth outstanding_p.
REQ-018 full SHALL be registered state (count==outstanding_p); a pop in the same cycle SHALL NOT unblock a push when full.
REQ-019 The block SHALL route responses in order: resp_v_o[h] = cache_v_i & ~empty, where h is the FIFO head ID; all other resp_v_o bits SHALL be 0.
REQ-020 resp_data_o SHALL equal cache_data_i, broadcast to all requesters.
REQ-021 cache_yumi_o SHALL equal cache_v_i & ~empty & resp_yumi_i[h], and SHALL pop the FIFO.
REQ-022 On a simultaneous push and pop, the count SHALL be unchanged and both pointers SHALL advance, with the FIFO wrapping modulo outstanding_p.
REQ-023 When cache_v_i=1 while the FIFO is empty, all resp_v_o bits and cache_yumi_o SHALL be 0, and a simulation-only error SHALL be printed.
REQ-024 outstanding_o SHALL equal the FIFO count, updated one cycle after each push or pop.

Reset
REQ-025 While reset_i is asserted (asynchronously): rr_ptr=0, FIFO empty, outstanding_o=0, cache_v_o=0, req_yumi_o=0, resp_v_o=0, cache_yumi_o=0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight IDs, and no response SHALL be routed until new requests are accepted.

Verification
REQ-027 req_v_i=2'b11 held, cache_yumi_i=1 and responses drained every cycle -> accepted grants alternate 0,1,0,1; outstanding_o never exceeds 1.
REQ-028 Only requester 1 is valid for 3 cycles with cache_yumi_i=1 -> three grants to 1, rr_ptr=0 after each; requester 0 is never yumi'd.
REQ-029 Four requests accepted with no responses (outstanding_p=4) -> outstanding_o=4, cache_v_o=0 despite req_v_i=1; the first response then returns with resp_v_o equal to the first-granted ID.
REQ-030 Responses for IDs 0,1,0 with resp_yumi_i[1]=0 for 5 cycles -> second response stalls, cache_yumi_o=0, third is not delivered early, and order is preserved.
REQ-031 Simultaneous push and pop at count=2 -> count stays 2; reset_i pulsed with 3 outstanding -> outputs zero immediately and outstanding_o=0 after release.

Source files
------------

// File: rtl/bsg_cache_req_arbiter.sv
// bsg_cache_req_arbiter: round-robin arbiter sharing one bsg_cache, with in-order response routing.
package bsg_cache_req_arbiter_pkg;
  function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
    return 6 + addr_width + data_width + data_width / 8;
  endfunction
endpackage

module bsg_cache_req_arbiter
  import bsg_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int pkt_width_p   = bsg_cache_pkt_width(32, 32),
  parameter int data_width_p  = 32,
  parameter int outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic [pkt_width_p-1:0]           cache_pkt_o,
  output logic                             cache_v_o,
  input  logic                             cache_yumi_i,
  input  logic [data_width_p-1:0]          cache_data_i,
  input  logic                             cache_v_i,
  output logic                             cache_yumi_o,
  output logic [data_width_p-1:0]          resp_data_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  output logic [$clog2(outstanding_p+1)-1:0] outstanding_o
);
  localparam int lg_req_lp = $clog2(num_req_p);
  localparam int lg_out_lp = $clog2(outstanding_p);
  localparam int cnt_w_lp  = $clog2(outstanding_p + 1);
  logic [lg_req_lp-1:0] rr_q, rr_d, g, h;
  logic [lg_out_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic full_q, full_d, empty, push, pop;
  logic [lg_req_lp-1:0] mem_q [outstanding_p];
  // Scan offsets from farthest to nearest so the first valid at or after rr_q wins.
  always_comb begin
    logic [lg_req_lp:0] idx;
    g = rr_q;
    idx = '0;
    for (int j = num_req_p - 1; j >= 0; j--) begin
      idx = {1'b0, rr_q} + (lg_req_lp+1)'(j);
      idx = (idx >= (lg_req_lp+1)'(num_req_p)) ? idx - (lg_req_lp+1)'(num_req_p) : idx;
      if (req_v_i[idx[lg_req_lp-1:0]]) g = idx[lg_req_lp-1:0];
    end
  end
  assign empty        = (cnt_q == '0);
  assign h            = mem_q[rptr_q];
  assign cache_v_o    = ~reset_i & (|req_v_i) & ~full_q;
  assign cache_pkt_o  = req_pkt_i[g*pkt_width_p +: pkt_width_p];
  assign push         = cache_v_o & cache_yumi_i;
  assign req_yumi_o   = push ? num_req_p'(1) << g : '0;
  assign resp_data_o  = cache_data_i;
  assign resp_v_o     = (~reset_i & cache_v_i & ~empty) ? num_req_p'(1) << h : '0;
  assign cache_yumi_o = ~reset_i & cache_v_i & ~empty & resp_yumi_i[h];
  assign pop          = cache_yumi_o;
  assign outstanding_o = cnt_q;
  always_comb begin
    rr_d   = push ? ((g == lg_req_lp'(num_req_p - 1)) ? '0 : g + 1'b1) : rr_q;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    full_d = (cnt_d == cnt_w_lp'(outstanding_p));
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end
  // ID storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= g;
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && cache_v_i && empty) $error("bsg_cache_req_arbiter: cache response with no request outstanding");
  end
`endif
endmodule

// File: tb/tb_bsg_cache_req_arbiter.sv
// tb_bsg_cache_req_arbiter: directed and random checks against a queue-based reference model.
module tb_bsg_cache_req_arbiter;
  localparam int N = 2, PW = 16, DW = 32, OUT = 4;
  logic clk_i = 1'b0, reset_i;
  logic [N*PW-1:0] req_pkt_i;
  logic [N-1:0] req_v_i, req_yumi_o, resp_v_o, resp_yumi_i;
  logic [PW-1:0] cache_pkt_o;
  logic cache_v_o, cache_yumi_i, cache_v_i, cache_yumi_o;
  logic [DW-1:0] cache_data_i, resp_data_o;
  logic [$clog2(OUT+1)-1:0] outstanding_o;
  int total = 0, bad = 0, rr = 0;
  int q[$];
  int grants[$];

  bsg_cache_req_arbiter #(.num_req_p(N), .pkt_width_p(PW), .data_width_p(DW), .outstanding_p(OUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_yumi_o(req_yumi_o),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_yumi_i(cache_yumi_i),
    .cache_data_i(cache_data_i), .cache_v_i(cache_v_i), .cache_yumi_o(cache_yumi_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .outstanding_o(outstanding_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle's combinational outputs, then advances the model across the clock edge.
  task automatic cyc();
    int g;
    logic [N-1:0] ery, erv;
    logic ecv, acc, pop;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && req_v_i[(rr + k) % N]) g = (rr + k) % N;
    ecv = !reset_i && g >= 0 && q.size() < OUT;
    acc = ecv && cache_yumi_i;
    ery = acc ? N'(1) << g : '0;
    erv = (!reset_i && cache_v_i && q.size() > 0) ? N'(1) << q[0] : '0;
    pop = erv != '0 && resp_yumi_i[q[0]];
    chk("cache_v", 64'(cache_v_o), 64'(ecv));
    chk("req_yumi", 64'(req_yumi_o), 64'(ery));
    chk("resp_v", 64'(resp_v_o), 64'(erv));
    chk("cache_yumi", 64'(cache_yumi_o), 64'(pop));
    chk("outstanding", 64'(outstanding_o), reset_i ? 64'd0 : 64'(q.size()));
    chk("resp_data", 64'(resp_data_o), 64'(cache_data_i));
    if (ecv) chk("cache_pkt", 64'(cache_pkt_o), 64'(req_pkt_i[g*PW +: PW]));
    @(posedge clk_i);
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(g);
      grants.push_back(g);
      rr = (g + 1) % N;
    end
    #1;
  endtask

  initial begin
    reset_i = 1'b1; req_v_i = 2'b11; cache_yumi_i = 1'b1; cache_v_i = 1'b0; resp_yumi_i = 2'b11;
    req_pkt_i = 32'hBEEF_1234; cache_data_i = 32'h5555_AAAA;
    cyc(); cyc();
    reset_i = 1'b0;
    // Alternating grants with responses drained every cycle.
    for (int i = 0; i < 6; i++) begin
      cache_v_i = q.size() > 0;
      cyc();
    end
    for (int i = 0; i < 4; i++) chk("alt_grant", 64'(grants[i]), 64'(i % 2));
    req_v_i = '0; cache_v_i = 1'b1; cyc();
    // Only requester 1 valid.
    grants.delete();
    req_v_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cache_v_i = q.size() > 0;
      cyc();
    end
    for (int i = 0; i < 3; i++) chk("only1_grant", 64'(grants[i]), 64'd1);
    req_v_i = '0; cache_v_i = 1'b1; cyc();
    cache_v_i = 1'b0;
    // Fill to capacity with no responses.
    grants.delete();
    req_v_i = 2'b11; cache_data_i = 32'h1357_9BDF;
    for (int i = 0; i < 6; i++) cyc();
    chk("full_count", 64'(outstanding_o), 64'd4);
    chk("full_block", 64'(cache_v_o), 64'd0);
    req_v_i = '0; cache_v_i = 1'b1; #1;
    chk("first_resp", 64'(resp_v_o), 64'(N'(1) << grants[0]));
    for (int i = 0; i < 4; i++) cyc();
    cache_v_i = 1'b0;
    // Responses for IDs 0,1,0 with requester 1 stalling.
    rr = rr;
    req_pkt_i = 32'h0A0A_0B0B;
    while (q.size() < 3) begin
      req_v_i = (rr == 0) ? 2'b01 : 2'b10;
      if (q.size() == 0 && rr != 0) req_v_i = 2'b11;
      cyc();
    end
    req_v_i = '0; cache_v_i = 1'b1; resp_yumi_i = 2'b01;
    for (int i = 0; i < 6; i++) cyc();
    resp_yumi_i = 2'b11;
    while (q.size() > 0) cyc();
    cache_v_i = 1'b0;
    // Push and pop together at count 2.
    req_v_i = 2'b11;
    cyc(); cyc();
    chk("cnt2_pre", 64'(outstanding_o), 64'd2);
    cache_v_i = 1'b1; cyc();
    chk("cnt2_post", 64'(outstanding_o), 64'd2);
    cache_v_i = 1'b0; cyc();
    chk("cnt3", 64'(outstanding_o), 64'd3);
    // Asynchronous reset with three in flight.
    #2 reset_i = 1'b1;
    #1;
    chk("rst_cache_v", 64'(cache_v_o), 64'd0);
    chk("rst_req_yumi", 64'(req_yumi_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    cache_v_i = 1'b1; #1;
    chk("rst_resp_v", 64'(resp_v_o), 64'd0);
    chk("rst_cache_yumi", 64'(cache_yumi_o), 64'd0);
    cache_v_i = 1'b0;
    q.delete(); rr = 0;
    cyc();
    reset_i = 1'b0; req_v_i = '0;
    cyc();
    chk("post_rst_out", 64'(outstanding_o), 64'd0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_v_i = N'($urandom);
      cache_yumi_i = 1'($urandom);
      cache_v_i = 1'($urandom) & (q.size() > 0);
      resp_yumi_i = N'($urandom);
      req_pkt_i = {$urandom, $urandom};
      cache_data_i = $urandom;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
